// File: rtl/compare_unit.sv
// CP0 timer compare: holds Compare, detects rising Count==Compare matches
// and raises a level timer interrupt that stays up until acked or Compare is rewritten.
`ifndef UNKNOW
`define UNKNOW 'x
`endif

module compare_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] count,
   input  logic             r_p,
   input  logic             r_h,
   input  logic             we_p,
   input  logic [WIDTH-1:0] wdata,
   input  logic             ack,
   output logic [WIDTH-1:0] read_data,
   output logic             timer_irq,
   output logic             match_pulse,
   output logic             armed
);

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      PENDING  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] compare;
   logic             match_q;
   logic             match;
   logic             rise;

   assign match       = (count == compare);
   // Edge-qualified so a Count stalled on Compare fires only once.
   assign rise        = match & ~match_q;
   assign match_pulse = (state == ARMED) & rise & ~we_p;
   assign read_data   = (r_p | r_h) ? compare : `UNKNOW;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         compare   <= '0;
         match_q   <= 1'b0;
         state     <= DISARMED;
         timer_irq <= 1'b0;
         armed     <= 1'b0;
      end else begin
         match_q <= match;
         if (we_p)
            compare <= wdata;
         case (state)
            DISARMED: begin
               if (we_p) begin
                  state <= ARMED;
                  armed <= 1'b1;
               end
            end
            ARMED: begin
               // A Compare write in the match cycle wins; the old-compare match is dropped.
               if (!we_p && rise) begin
                  state     <= PENDING;
                  armed     <= 1'b0;
                  timer_irq <= 1'b1;
               end
            end
            PENDING: begin
               if (we_p || ack) begin
                  state     <= ARMED;
                  armed     <= 1'b1;
                  timer_irq <= 1'b0;
               end
            end
            default: begin
               state     <= DISARMED;
               armed     <= 1'b0;
               timer_irq <= 1'b0;
            end
         endcase
      end
   end

endmodule
